// File: rtl/uart_result_framer.sv
// Frames one latched result word as SYNC, data bytes, XOR checksum for a UART TX.
// Pacing uses TX_Active only; a missing TX_Active rise raises a sticky ERR.
module uart_result_framer #(
    parameter int         DATA_BYTES    = 4,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter bit         MSB_FIRST     = 1'b1,
    parameter int         START_TIMEOUT = 15
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LOAD,
    input  logic [8*DATA_BYTES-1:0] DATA_IN,
    output logic                    READY,
    output logic                    FRAME_DONE,
    output logic                    ERR,
    output logic                    TX_DV,
    output logic [7:0]              TX_Byte,
    input  logic                    TX_Active
);
    localparam int W  = 8 * DATA_BYTES;
    localparam int IW = $clog2(DATA_BYTES + 2);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BYTES + 1);
    localparam logic [TW-1:0] TMAX     = TW'(START_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACT,
        WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    chk_q, chk_d;
    logic [W-1:0]  word_q, word_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          dv_q, dv_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    cur_data;

    // The latched word is shifted so the next data byte always sits at one end.
    assign cur_data = MSB_FIRST ? word_q[W-1 -: 8] : word_q[7:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        chk_d   = chk_q;
        word_d  = word_q;
        err_d   = err_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (LOAD && ready_q) begin
                    word_d  = DATA_IN;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    chk_d   = '0;
                    tmr_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!TX_Active) begin
                    dv_d    = 1'b1;
                    tmr_d   = '0;
                    state_d = WAIT_ACT;
                    unique case (1'b1)
                        (idx_q == '0):      byte_d = SYNC_BYTE;
                        (idx_q == LAST_IDX): byte_d = chk_q;
                        default: begin
                            byte_d = cur_data;
                            chk_d  = chk_q ^ cur_data;
                            word_d = MSB_FIRST ? (word_q << 8) : (word_q >> 8);
                        end
                    endcase
                end
            end
            WAIT_ACT: begin
                if (TX_Active) begin
                    state_d = WAIT_DONE;
                end else begin
                    if (tmr_q != TMAX) tmr_d = tmr_q + TW'(1);
                    if (tmr_d == TMAX) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!TX_Active) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // READY stays low in the FRAME_DONE cycle so a coincident LOAD is dropped.
        ready_d = (state_d == IDLE) && !done_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            chk_q   <= '0;
            word_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            chk_q   <= chk_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            byte_q  <= byte_d;
        end
    end

    assign READY      = ready_q;
    assign FRAME_DONE = done_q;
    assign ERR        = err_q;
    assign TX_DV      = dv_q;
    assign TX_Byte    = byte_q;
endmodule

// File: tb/tb_uart_result_framer.sv
// Bench for uart_result_framer: MSB- and LSB-first instances share stimulus and
// are checked against a frame-level byte model with a simple UART busy model.
module tb_uart_result_framer;
    localparam int N  = 4;
    localparam int W  = 8 * N;
    localparam int FB = 8 * (N + 2);
    localparam int TO = 15;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] din  = '0;
    logic         ready [2];
    logic         fdone [2];
    logic         err   [2];
    logic         txdv  [2];
    logic [7:0]   txb   [2];
    logic         txact [2];
    logic         act_r [2];
    int           cnt   [2];
    logic         stuck    = 1'b0;
    logic         force_hi = 1'b0;
    int           ft       = 4;
    int           checks   = 0;
    int           failures = 0;
    logic [7:0]   exp_f [2][N+2];
    int           pos   [2];
    logic [FB-1:0] got  [2];
    logic         dv_prev [2];
    logic         fd_prev [2];
    logic         hold_ok [2];
    logic [7:0]   last_b  [2];

    always #5 clk = ~clk;

    uart_result_framer #(
        .DATA_BYTES(N), .SYNC_BYTE(8'hA5), .MSB_FIRST(1'b1), .START_TIMEOUT(TO)
    ) dut_msb (
        .CLK(clk), .RST(rst), .LOAD(load), .DATA_IN(din),
        .READY(ready[0]), .FRAME_DONE(fdone[0]), .ERR(err[0]),
        .TX_DV(txdv[0]), .TX_Byte(txb[0]), .TX_Active(txact[0])
    );

    uart_result_framer #(
        .DATA_BYTES(N), .SYNC_BYTE(8'hA5), .MSB_FIRST(1'b0), .START_TIMEOUT(TO)
    ) dut_lsb (
        .CLK(clk), .RST(rst), .LOAD(load), .DATA_IN(din),
        .READY(ready[1]), .FRAME_DONE(fdone[1]), .ERR(err[1]),
        .TX_DV(txdv[1]), .TX_Byte(txb[1]), .TX_Active(txact[1])
    );

    assign txact[0] = force_hi | act_r[0];
    assign txact[1] = force_hi | act_r[1];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    // Expected frame: index 0 MSB-first instance, index 1 LSB-first instance.
    function automatic void build(input logic [W-1:0] d);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        exp_f[0][0] = 8'hA5;
        exp_f[1][0] = 8'hA5;
        for (int i = 0; i < N; i++) begin
            b = d[8*(N-1-i) +: 8];
            exp_f[0][i+1] = b;
            exp_f[1][N-i] = b;
            x = x ^ b;
        end
        exp_f[0][N+1] = x;
        exp_f[1][N+1] = x;
    endfunction

    function automatic logic [FB-1:0] flat(input int k);
        logic [FB-1:0] r;
        r = '0;
        for (int i = 0; i < N + 2; i++) r = {r[FB-9:0], exp_f[k][i]};
        return r;
    endfunction

    // Transmitter: busy from the cycle after TX_DV for ft cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!act_r[k]) begin
                if (txdv[k] && !stuck) begin
                    act_r[k] <= 1'b1;
                    cnt[k]   <= ft - 1;
                end
            end else if (cnt[k] == 0) begin
                act_r[k] <= 1'b0;
            end else begin
                cnt[k] <= cnt[k] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                dv_prev[k] = 1'b0;
                fd_prev[k] = 1'b0;
                hold_ok[k] = 1'b0;
            end else begin
                if (txdv[k]) begin
                    chk($sformatf("dv_width%0d", k), dv_prev[k], 1'b0);
                    chk($sformatf("dv_ready%0d", k), ready[k], 1'b0);
                    if (pos[k] < N + 2) begin
                        chk($sformatf("byte%0d_%0d", pos[k], k), txb[k], exp_f[k][pos[k]]);
                        got[k] = {got[k][FB-9:0], txb[k]};
                    end else begin
                        chk($sformatf("extra_byte%0d", k), pos[k], N + 1);
                    end
                    pos[k]++;
                    last_b[k]  = txb[k];
                    hold_ok[k] = 1'b1;
                end else if (txact[k] && !force_hi && hold_ok[k]) begin
                    chk($sformatf("byte_hold%0d", k), txb[k], last_b[k]);
                end
                if (fdone[k]) begin
                    chk($sformatf("done_width%0d", k), fd_prev[k], 1'b0);
                    chk($sformatf("done_count%0d", k), pos[k], N + 2);
                    chk($sformatf("done_err%0d", k), err[k], 1'b0);
                end
                dv_prev[k] = txdv[k];
                fd_prev[k] = fdone[k];
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready[0] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ready[0], 1'b1);
    endtask

    task automatic start(input logic [W-1:0] d, input bit lat);
        load = 1'b1;
        din  = d;
        build(d);
        pos[0] = 0;
        pos[1] = 0;
        @(negedge clk);
        load = 1'b0;
        din  = $urandom;
        chk("acc_dv0", txdv[0], 1'b0);
        chk("acc_ready0", ready[0], 1'b0);
        if (lat) begin
            @(negedge clk);
            chk("lat_dv", txdv[0], 1'b1);
            chk("lat_dv_lsb", txdv[1], 1'b1);
        end
    endtask

    task automatic run_frame(input bit spam);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (fdone[0] || err[0]) break;
            if (spam) begin
                load = 1'($urandom_range(0, 1));
                din  = $urandom;
            end
        end
        load = 1'b0;
        chk("frame_end", fdone[0], 1'b1);
    endtask

    initial begin
        logic [W-1:0] d;
        int c;
        for (int k = 0; k < 2; k++) begin
            act_r[k] = 1'b0; cnt[k] = 0; pos[k] = 0; got[k] = '0;
            dv_prev[k] = 1'b0; fd_prev[k] = 1'b0; hold_ok[k] = 1'b0; last_b[k] = '0;
        end
        build(32'h12345678);
        chk("model_msb", flat(0), 48'hA51234567808);
        chk("model_lsb", flat(1), 48'hA57856341208);
        build(32'h13579BDF);
        chk("model_xor0", flat(1), 48'hA5DF9B571300);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", ready[k], 1'b1);
            chk("rst_dv", txdv[k], 1'b0);
            chk("rst_byte", txb[k], 8'h00);
            chk("rst_done", fdone[k], 1'b0);
            chk("rst_err", err[k], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);

        ft = 6;
        wait_ready();
        start(32'h12345678, 1'b1);
        run_frame(1'b0);
        chk("t1_msb_seq", got[0], 48'hA51234567808);
        chk("t2_lsb_seq", got[1], 48'hA57856341208);
        chk("t1_pulses", pos[0], N + 2);
        chk("t1_err", err[0], 1'b0);

        wait_ready();
        stuck = 1'b1;
        start(32'hCAFEF00D, 1'b1);
        repeat (TO - 1) @(negedge clk);
        chk("t3_err_early", err[0], 1'b0);
        @(negedge clk);
        chk("t3_err", err[0], 1'b1);
        chk("t3_err_lsb", err[1], 1'b1);
        chk("t3_ready", ready[0], 1'b1);
        chk("t3_no_done", fdone[0], 1'b0);
        stuck = 1'b0;
        @(negedge clk);
        chk("t3_err_sticky", err[0], 1'b1);
        start(32'h0BADBEEF, 1'b1);
        chk("t3_err_clear", err[0], 1'b0);
        run_frame(1'b0);

        wait_ready();
        ft = 5;
        start(32'h13579BDF, 1'b1);
        run_frame(1'b1);
        chk("t4_msb_seq", got[0], 48'hA513579BDF00);
        chk("t4_lsb_seq", got[1], 48'hA5DF9B571300);
        load = 1'b1;
        din  = '1;
        @(negedge clk);
        d = 32'h01020408;
        din = d;
        build(d);
        pos[0] = 0;
        pos[1] = 0;
        @(negedge clk);
        load = 1'b0;
        chk("t4_acc_dv0", txdv[0], 1'b0);
        @(negedge clk);
        chk("t4_acc_dv1", txdv[0], 1'b1);
        run_frame(1'b0);
        chk("t4_new_msb", got[0], 48'hA5010204080F);
        chk("t4_new_lsb", got[1], 48'hA5080402010F);

        wait_ready();
        force_hi = 1'b1;
        start(32'hDEADBEEF, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("t5_hold_dv", txdv[0], 1'b0);
        end
        force_hi = 1'b0;
        @(negedge clk);
        chk("t5_dv_after_fall", txdv[0], 1'b1);
        run_frame(1'b0);

        wait_ready();
        ft = 8;
        start(32'hA1B2C3D4, 1'b1);
        c = 1;
        for (int n = 0; n < 400 && c < 3; n++) begin
            @(negedge clk);
            if (txdv[0]) c++;
        end
        chk("t6_reached_byte2", c, 3);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_rst_dv", txdv[k], 1'b0);
            chk("t6_rst_ready", ready[k], 1'b1);
            chk("t6_rst_byte", txb[k], 8'h00);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        wait_ready();
        start(32'h00000000, 1'b0);
        run_frame(1'b0);
        chk("t6_zero_msb", got[0], 48'hA50000000000);
        chk("t6_zero_lsb", got[1], 48'hA50000000000);

        for (int f = 0; f < 20; f++) begin
            wait_ready();
            ft = $urandom_range(2, 12);
            d  = $urandom;
            start(d, 1'b1);
            run_frame(1'b1);
            chk("rnd_msb_seq", got[0], flat(0));
            chk("rnd_lsb_seq", got[1], flat(1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
